// File: rtl/fetch_group_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_group_unit
// Brief    : 4-wide fetch stage. Holds the fetch PC and registers four
//            consecutive instruction words into the decode latch.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_group_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] IMEM_LIMIT = 32'h0000_0400
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [2:0]  PCPlusSrc,
    input  logic        BTAPstall,
    input  logic        ROBFlush,
    input  logic [31:0] ROBRedirectPC,
    output logic [31:0] IAddr1,
    output logic [31:0] IAddr2,
    output logic [31:0] IAddr3,
    output logic [31:0] IAddr4,
    input  logic [31:0] IData1,
    input  logic [31:0] IData2,
    input  logic [31:0] IData3,
    input  logic [31:0] IData4,
    output logic [31:0] InstrD1,
    output logic [31:0] InstrD2,
    output logic [31:0] InstrD3,
    output logic [31:0] InstrD4,
    output logic [31:0] PCPlus4D1,
    output logic [31:0] PCPlus4D2,
    output logic [31:0] PCPlus4D3,
    output logic [31:0] PCPlus4D4,
    output logic [3:0]  ValidD,
    output logic [31:0] FetchPC
);

    logic [31:0] r_pc;
    logic [31:0] r_instr [4];
    logic [31:0] r_pc4   [4];
    logic [3:0]  r_valid;

    logic [31:0] w_fetch_pc;
    logic [31:0] w_redirect_pc;
    logic        w_replay;
    logic [2:0]  w_src_m1;
    logic        w_load;
    logic [31:0] w_addr  [4];
    logic [31:0] w_idata [4];
    logic [3:0]  w_slot_ok;

    assign w_redirect_pc = {ROBRedirectPC[31:2], 2'b00};
    // Codes 5..7 are illegal and behave exactly like code 0.
    assign w_replay      = (PCPlusSrc != 3'd0) && (PCPlusSrc <= 3'd4);
    assign w_src_m1      = PCPlusSrc - 3'd1;
    assign w_load        = w_replay || !BTAPstall;

    always_comb begin
        w_fetch_pc = r_pc;
        if (reset) begin
            w_fetch_pc = RESET_PC;
        end else if (ROBFlush) begin
            w_fetch_pc = w_redirect_pc;
        end else if (w_replay) begin
            w_fetch_pc = r_pc4[w_src_m1[1:0]] - 32'd4;
        end
    end

    assign w_idata[0] = IData1;
    assign w_idata[1] = IData2;
    assign w_idata[2] = IData3;
    assign w_idata[3] = IData4;

    generate
        for (genvar n = 0; n < 4; n++) begin : g_slot
            assign w_addr[n]    = w_fetch_pc + 32'(4 * n);
            assign w_slot_ok[n] = (w_addr[n] < IMEM_LIMIT);
        end
    endgenerate

    // A flush loads a bubble; PCPlus4D keeps its previous contents.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_pc    <= RESET_PC;
            r_valid <= 4'b0000;
            for (int n = 0; n < 4; n++) begin
                r_instr[n] <= 32'd0;
                r_pc4[n]   <= 32'd0;
            end
        end else if (ROBFlush) begin
            r_pc    <= w_redirect_pc;
            r_valid <= 4'b0000;
            for (int n = 0; n < 4; n++) begin
                r_instr[n] <= 32'd0;
            end
        end else if (w_load) begin
            r_pc    <= w_fetch_pc + 32'd16;
            r_valid <= w_slot_ok;
            for (int n = 0; n < 4; n++) begin
                r_instr[n] <= w_slot_ok[n] ? w_idata[n] : 32'd0;
                r_pc4[n]   <= w_addr[n] + 32'd4;
            end
        end
    end

    assign FetchPC   = w_fetch_pc;
    assign IAddr1    = w_addr[0];
    assign IAddr2    = w_addr[1];
    assign IAddr3    = w_addr[2];
    assign IAddr4    = w_addr[3];
    assign InstrD1   = r_instr[0];
    assign InstrD2   = r_instr[1];
    assign InstrD3   = r_instr[2];
    assign InstrD4   = r_instr[3];
    assign PCPlus4D1 = r_pc4[0];
    assign PCPlus4D2 = r_pc4[1];
    assign PCPlus4D3 = r_pc4[2];
    assign PCPlus4D4 = r_pc4[3];
    assign ValidD    = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_fetch_group_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_group_unit
// Brief    : Directed vector table plus randomized run against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_group_unit;

    localparam logic [31:0] C_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] C_LIMIT    = 32'h0000_0048;

    logic        CLK = 1'b0;
    logic        reset;
    logic [2:0]  PCPlusSrc;
    logic        BTAPstall;
    logic        ROBFlush;
    logic [31:0] ROBRedirectPC;
    logic [31:0] IAddr1, IAddr2, IAddr3, IAddr4;
    logic [31:0] IData1, IData2, IData3, IData4;
    logic [31:0] InstrD1, InstrD2, InstrD3, InstrD4;
    logic [31:0] PCPlus4D1, PCPlus4D2, PCPlus4D3, PCPlus4D4;
    logic [3:0]  ValidD;
    logic [31:0] FetchPC;

    int vectors = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    assign IData1 = mem_word(IAddr1);
    assign IData2 = mem_word(IAddr2);
    assign IData3 = mem_word(IAddr3);
    assign IData4 = mem_word(IAddr4);

    fetch_group_unit #(
        .RESET_PC   (C_RESET_PC),
        .IMEM_LIMIT (C_LIMIT)
    ) dut (
        .CLK           (CLK),
        .reset         (reset),
        .PCPlusSrc     (PCPlusSrc),
        .BTAPstall     (BTAPstall),
        .ROBFlush      (ROBFlush),
        .ROBRedirectPC (ROBRedirectPC),
        .IAddr1        (IAddr1),
        .IAddr2        (IAddr2),
        .IAddr3        (IAddr3),
        .IAddr4        (IAddr4),
        .IData1        (IData1),
        .IData2        (IData2),
        .IData3        (IData3),
        .IData4        (IData4),
        .InstrD1       (InstrD1),
        .InstrD2       (InstrD2),
        .InstrD3       (InstrD3),
        .InstrD4       (InstrD4),
        .PCPlus4D1     (PCPlus4D1),
        .PCPlus4D2     (PCPlus4D2),
        .PCPlus4D3     (PCPlus4D3),
        .PCPlus4D4     (PCPlus4D4),
        .ValidD        (ValidD),
        .FetchPC       (FetchPC)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rst;
        logic [2:0]  src;
        logic        stall;
        logic        flush;
        logic [31:0] rpc;
        logic [31:0] fpc;
        logic [31:0] i1;
        logic [31:0] i4;
        logic [31:0] p1;
        logic [31:0] p4;
        logic [3:0]  v;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic [2:0] src, input logic stall,
                                input logic flush, input logic [31:0] rpc, input logic [31:0] fpc,
                                input logic [31:0] i1, input logic [31:0] i4, input logic [31:0] p1,
                                input logic [31:0] p4, input logic [3:0] v);
        vec_t t;
        t.rst = rst; t.src = src; t.stall = stall; t.flush = flush; t.rpc = rpc;
        t.fpc = fpc; t.i1 = i1; t.i4 = i4; t.p1 = p1; t.p4 = p4; t.v = v;
        return t;
    endfunction

    vec_t tbl [17];

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_instr [4];
    logic [31:0] m_pc4   [4];
    logic [3:0]  m_valid;

    initial begin
        reset = 1'b1; PCPlusSrc = 3'd0; BTAPstall = 1'b0; ROBFlush = 1'b0; ROBRedirectPC = 32'd0;

        //            rst src stl fl rpc            fetchpc       InstrD1        InstrD4        PC4D1  PC4D4  ValidD
        tbl[0]  = mk(1, 0, 0, 0, 32'h0,   32'h00, 32'h0,         32'h0,         32'h00, 32'h00, 4'h0);
        tbl[1]  = mk(0, 0, 0, 0, 32'h0,   32'h00, 32'h1000_0000, 32'h1000_0003, 32'h04, 32'h10, 4'hF);
        tbl[2]  = mk(0, 0, 0, 0, 32'h0,   32'h10, 32'h1000_0004, 32'h1000_0007, 32'h14, 32'h20, 4'hF);
        tbl[3]  = mk(0, 3, 0, 0, 32'h0,   32'h18, 32'h1000_0006, 32'h1000_0009, 32'h1C, 32'h28, 4'hF);
        tbl[4]  = mk(0, 0, 0, 0, 32'h0,   32'h28, 32'h1000_000A, 32'h1000_000D, 32'h2C, 32'h38, 4'hF);
        tbl[5]  = mk(0, 0, 1, 0, 32'h0,   32'h38, 32'h1000_000A, 32'h1000_000D, 32'h2C, 32'h38, 4'hF);
        tbl[6]  = mk(0, 0, 1, 0, 32'h0,   32'h38, 32'h1000_000A, 32'h1000_000D, 32'h2C, 32'h38, 4'hF);
        tbl[7]  = mk(0, 0, 1, 0, 32'h0,   32'h38, 32'h1000_000A, 32'h1000_000D, 32'h2C, 32'h38, 4'hF);
        tbl[8]  = mk(0, 0, 0, 0, 32'h0,   32'h38, 32'h1000_000E, 32'h1000_0011, 32'h3C, 32'h48, 4'hF);
        tbl[9]  = mk(0, 1, 1, 0, 32'h0,   32'h38, 32'h1000_000E, 32'h1000_0011, 32'h3C, 32'h48, 4'hF);
        tbl[10] = mk(0, 2, 0, 1, 32'h43,  32'h40, 32'h0,         32'h0,         32'h3C, 32'h48, 4'h0);
        tbl[11] = mk(0, 0, 0, 0, 32'h0,   32'h40, 32'h1000_0010, 32'h0,         32'h44, 32'h50, 4'h3);
        tbl[12] = mk(0, 0, 0, 0, 32'h0,   32'h50, 32'h0,         32'h0,         32'h54, 32'h60, 4'h0);
        tbl[13] = mk(1, 4, 0, 1, 32'h100, 32'h00, 32'h0,         32'h0,         32'h00, 32'h00, 4'h0);
        tbl[14] = mk(0, 0, 0, 0, 32'h0,   32'h00, 32'h1000_0000, 32'h1000_0003, 32'h04, 32'h10, 4'hF);
        tbl[15] = mk(0, 5, 0, 0, 32'h0,   32'h10, 32'h1000_0004, 32'h1000_0007, 32'h14, 32'h20, 4'hF);
        tbl[16] = mk(0, 6, 1, 0, 32'h0,   32'h20, 32'h1000_0004, 32'h1000_0007, 32'h14, 32'h20, 4'hF);

        for (int r = 0; r < 17; r++) begin
            @(negedge CLK);
            reset = tbl[r].rst; PCPlusSrc = tbl[r].src; BTAPstall = tbl[r].stall;
            ROBFlush = tbl[r].flush; ROBRedirectPC = tbl[r].rpc;
            #1;
            chk($sformatf("tbl%0d FetchPC", r), FetchPC, tbl[r].fpc);
            @(posedge CLK);
            #1;
            chk($sformatf("tbl%0d InstrD1", r), InstrD1, tbl[r].i1);
            chk($sformatf("tbl%0d InstrD4", r), InstrD4, tbl[r].i4);
            chk($sformatf("tbl%0d PCPlus4D1", r), PCPlus4D1, tbl[r].p1);
            chk($sformatf("tbl%0d PCPlus4D4", r), PCPlus4D4, tbl[r].p4);
            chk($sformatf("tbl%0d ValidD", r), {28'd0, ValidD}, {28'd0, tbl[r].v});
        end

        // Randomized run; first cycle is a reset so the model starts in sync.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] mf;
            logic [31:0] a;
            int t;
            @(negedge CLK);
            reset     = (i == 0) || ($urandom_range(0, 49) == 0);
            ROBFlush  = ($urandom_range(0, 9) == 0);
            BTAPstall = ($urandom_range(0, 4) == 0);
            t = $urandom_range(0, 15);
            PCPlusSrc = (t < 9) ? 3'd0 : 3'($urandom_range(1, 7));
            ROBRedirectPC = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                        : 32'($urandom_range(0, 32'h60));

            if (reset)
                mf = C_RESET_PC;
            else if (ROBFlush)
                mf = ROBRedirectPC & ~32'd3;
            else if (PCPlusSrc >= 3'd1 && PCPlusSrc <= 3'd4)
                mf = m_pc4[int'(PCPlusSrc) - 1] - 32'd4;
            else
                mf = m_pc;

            #1;
            chk($sformatf("rnd%0d FetchPC", i), FetchPC, mf);
            chk($sformatf("rnd%0d IAddr4", i), IAddr4, mf + 32'd12);

            if (reset) begin
                m_pc = C_RESET_PC; m_valid = 4'd0;
                for (int n = 0; n < 4; n++) begin m_instr[n] = 32'd0; m_pc4[n] = 32'd0; end
            end else if (ROBFlush) begin
                m_pc = mf; m_valid = 4'd0;
                for (int n = 0; n < 4; n++) m_instr[n] = 32'd0;
            end else if ((PCPlusSrc >= 3'd1 && PCPlusSrc <= 3'd4) || !BTAPstall) begin
                for (int n = 0; n < 4; n++) begin
                    a = mf + 32'(4 * n);
                    m_valid[n] = (a < C_LIMIT);
                    m_instr[n] = m_valid[n] ? mem_word(a) : 32'd0;
                    m_pc4[n]   = a + 32'd4;
                end
                m_pc = mf + 32'd16;
            end

            @(posedge CLK);
            #1;
            chk($sformatf("rnd%0d InstrD1", i), InstrD1, m_instr[0]);
            chk($sformatf("rnd%0d InstrD2", i), InstrD2, m_instr[1]);
            chk($sformatf("rnd%0d InstrD3", i), InstrD3, m_instr[2]);
            chk($sformatf("rnd%0d InstrD4", i), InstrD4, m_instr[3]);
            chk($sformatf("rnd%0d PCPlus4D1", i), PCPlus4D1, m_pc4[0]);
            chk($sformatf("rnd%0d PCPlus4D2", i), PCPlus4D2, m_pc4[1]);
            chk($sformatf("rnd%0d PCPlus4D3", i), PCPlus4D3, m_pc4[2]);
            chk($sformatf("rnd%0d PCPlus4D4", i), PCPlus4D4, m_pc4[3]);
            chk($sformatf("rnd%0d ValidD", i), {28'd0, ValidD}, {28'd0, m_valid});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_group_unit.md
# fetch_group_unit

4-wide instruction fetch stage for the superscalar MIPS core. Holds the architectural fetch PC and reads four consecutive instruction words per cycle from the instruction memory. Registers them with their PC+4 values into the decode-stage latch that drives InstrD1..4 / PCPlus4D1..4. Acts on the decode stage's partial-dispatch replay code (PCPlusSrc), its BTAP stall, and ROB flush redirects.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: fetch PC loaded on reset.
- IMEM_LIMIT, 32'h0000_0400: first byte address beyond valid instruction memory; slots at or above it are invalid.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- PCPlusSrc  in  3  replay code from decode: 0 = group fully dispatched; k in 1..4 = slots k-1..3 not dispatched; 5..7 illegal.
- BTAPstall  in  1  decode waiting on branch predictor; freeze fetch.
- ROBFlush  in  1  mispredict/exception flush from ROB.
- ROBRedirectPC  in  32  restart address, valid with ROBFlush.
- IAddr1..IAddr4  out  32 each  combinational read addresses, FetchPC + 0/4/8/12.
- IData1..IData4  in  32 each  combinational read data for IAddr1..4.
- InstrD1..InstrD4  out  32 each  registered instruction words to decode.
- PCPlus4D1..PCPlus4D4  out  32 each  registered PC+4 of each slot.
- ValidD  out  4  per-slot valid; bit n-1 corresponds to slot n.
- FetchPC  out  32  combinational address of the group fetched this cycle.

## Operation
- State: PC register (next sequential group address); decode latch (4 × instr, 4 × PC+4, ValidD).
- FetchPC selection, priority high to low:
  - reset: RESET_PC.
  - ROBFlush: {ROBRedirectPC[31:2], 2'b00}.
  - PCPlusSrc = k in 1..4: PCPlus4D{k} − 4, the PC of the first undispatched slot.
  - Otherwise: PC.
  - PCPlusSrc 5..7 is treated as 0.
- Update at each posedge, highest-priority matching row only:
  - reset: PC ← RESET_PC; InstrD ← 0; PCPlus4D ← 0; ValidD ← 0.
  - ROBFlush: latch loaded with a bubble (InstrD = 0, ValidD = 0); PC ← redirect address. Fetch resumes the next cycle, giving a one-cycle flush bubble.
  - PCPlusSrc ≠ 0: latch loaded from FetchPC; PC ← FetchPC + 16. Replay overrides BTAPstall.
  - BTAPstall: latch and PC hold.
  - Else: latch loaded from FetchPC; PC ← FetchPC + 16.
- Slot load rule: slot n (n = 1..4), addr = FetchPC + 4(n−1).
  - If addr < IMEM_LIMIT: InstrDn ← IDatan; ValidD[n−1] ← 1.
  - Else: InstrDn ← 0 (sll r0 NOP); ValidD[n−1] ← 0.
  - PCPlus4Dn ← addr + 4 in all cases.
- Arithmetic is 32-bit modulo 2^32. A group may straddle IMEM_LIMIT, giving partial validity.

## Timing
- One-cycle fetch latency: FetchPC at cycle t becomes InstrD/PCPlus4D/ValidD after posedge t+1.
- Sequential throughput: 4 instructions per cycle; PC advances by 16.
- Replay: slot k−1 appears in InstrD1 one cycle after PCPlusSrc = k is sampled. No instruction is lost or duplicated beyond the replayed slots.
- Flush: first redirected group is visible in InstrD two cycles after ROBFlush is sampled (bubble cycle, then group).
- Simultaneous events:
  - ROBFlush with PCPlusSrc ≠ 0 or BTAPstall: flush wins.
  - reset with anything: reset wins.
- Reset mid-operation: all outputs reach reset values after the next posedge; FetchPC = RESET_PC combinationally while reset is high.

## Test plan
- Reset then run, RESET_PC = 0, memory word i = 32'h1000_0000 + i. Cycle 1 InstrD1..4 = 10000000..10000003, PCPlus4D = 4, 8, 12, 16, ValidD = 4'hF. Cycle 2 InstrD1 = 10000004, PCPlus4D1 = 20.
- With latch PCPlus4D1..4 = 20..32, drive PCPlusSrc = 3 for one cycle. Next group starts at 0x18: InstrD1 = 10000006, PCPlus4D1 = 0x1C. Sequential next group starts at 0x28.
- Hold BTAPstall for 3 cycles. Outputs and PC are unchanged. Release: the group following the held one appears. PCPlusSrc = 1 with BTAPstall = 1 replays the whole group from PCPlus4D1 − 4.
- ROBFlush with ROBRedirectPC = 0x43. One bubble cycle (ValidD = 0, InstrD = 0), then group at 0x40, PCPlus4D1 = 0x44. Same-cycle PCPlusSrc = 2 is ignored.
- IMEM_LIMIT = 0x48, fetch group at 0x40: ValidD = 4'b0011, InstrD3 = InstrD4 = 0, PCPlus4D4 = 0x50.
- Assert reset mid-stream while PCPlusSrc = 4 and ROBFlush = 1. After the edge all outputs are zero, ValidD = 0, FetchPC = RESET_PC.
